// File: rtl/seg7_pkg.sv
// seg7_pkg: seven-segment encodings and pattern classes shared by the display reader
package seg7_pkg;

    typedef enum logic [1:0] {HEX, BLANK, BAD} seg_class_t;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Active-low {g,f,e,d,c,b,a}, indexed by nibble; matches the display drive table
    localparam logic [6:0] SEG_HEX [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

endpackage

// File: rtl/seg7_pattern_lookup.sv
// seg7_pattern_lookup: inverse of the hex-to-segment table, pattern -> {class, nibble}
module seg7_pattern_lookup
    import seg7_pkg::*;
(
    input  logic [6:0] pattern,
    output logic [1:0] cls,
    output logic [3:0] nibble
);

    always_comb begin
        cls = (pattern == SEG_BLANK) ? BLANK : BAD;
        nibble = 4'h0;
        for (int n = 0; n < 16; n++) begin
            if (pattern == SEG_HEX[n]) begin
                cls = HEX;
                nibble = 4'(n);
            end
        end
    end

endmodule

// File: rtl/seg7_reader.sv
// seg7_reader: decodes a multiplexed active-low seven-segment bus back into hex frames
module seg7_reader
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [6:0]              seg_in,
    input  logic [NUM_DIGITS-1:0]   an_in,
    output logic [4*NUM_DIGITS-1:0] digits,
    output logic [NUM_DIGITS-1:0]   digit_valid,
    output logic [4*NUM_DIGITS-1:0] frame_data,
    output logic                    frame_valid,
    input  logic                    frame_ready,
    output logic                    bad_pattern,
    output logic                    overrun,
    input  logic                    clear_err
);

    localparam int CW = $clog2(STABLE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES - 1);

    logic [NUM_DIGITS+6:0]   hold;
    logic [CW-1:0]           cnt;
    logic                    captured;
    logic [NUM_DIGITS-1:0]   seen, sel, seen_n, dv_n;
    logic [4*NUM_DIGITS-1:0] digits_n;
    logic [1:0]              cls;
    logic [3:0]              nibble;
    logic                    same, one_hot, cap, emit;

    seg7_pattern_lookup u_lookup (
        .pattern (seg_in),
        .cls     (cls),
        .nibble  (nibble)
    );

    assign sel     = ~an_in;
    assign same    = {an_in, seg_in} == hold;
    assign one_hot = (sel != '0) && ((sel & (sel - NUM_DIGITS'(1))) == '0);
    assign cap     = same && (cnt == CNT_MAX) && !captured && one_hot;

    always_comb begin
        digits_n = digits;
        dv_n = digit_valid;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (cap && sel[i]) begin
                digits_n[4*i +: 4] = (cls == HEX) ? nibble : digits[4*i +: 4];
                dv_n[i] = (cls == HEX);
            end
        end
        seen_n = cap ? (seen | sel) : seen;
        emit = &seen_n;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold        <= '1;
            cnt         <= '0;
            captured    <= 1'b0;
            seen        <= '0;
            digits      <= '0;
            digit_valid <= '0;
            frame_data  <= '0;
            frame_valid <= 1'b0;
            bad_pattern <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            hold        <= {an_in, seg_in};
            cnt         <= !same ? '0 : (cnt == CNT_MAX) ? cnt : cnt + CW'(1);
            captured    <= same && (captured || cap);
            seen        <= emit ? '0 : seen_n;
            digits      <= digits_n;
            digit_valid <= dv_n;
            if (emit)
                frame_data <= digits_n;
            // A completion always (re)raises valid, even when the consumer takes the old frame
            frame_valid <= emit || (frame_valid && !frame_ready);
            bad_pattern <= (cap && cls == BAD) || (bad_pattern && !clear_err);
            overrun     <= (emit && frame_valid && !frame_ready) || (overrun && !clear_err);
        end
    end

endmodule
